block_noise_estimator: RTL and testbench

Parametrised successor to the single-channel per-frame noise estimator. Consumes a block-ordered multi-channel pixel stream from the memory reader / AXI read path, with a valid/ready handshake instead of a gated clock. Per pixel it computes the channel mean; per BLOCK_SIZE x BLOCK_SIZE block it computes the variance. Per frame it reports either the mean or the minimum block variance as estimated noise to the Wiener stage.

---
 rtl/block_noise_pkg.sv | 39 +++
 rtl/block_noise_estimator_var_acc.sv | 93 +++++++++
 rtl/block_noise_estimator.sv | 219 +++++++++++++++++++++
 tb/tb_block_noise_estimator.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_noise_pkg.sv
// ---------------------------------------------------------------------------
// block_noise_pkg
// Shared types and width helpers for the block noise estimator.
//   bne_state_t : control FSM state encoding
//   ln_of       : log2 of pixels per block (BLOCK_SIZE^2)
//   sum_w       : width of the per-block pixel sum
//   sumsq_w     : width of the per-block sum of squares
//   acc_w       : width of the frame variance accumulator
// ---------------------------------------------------------------------------
package block_noise_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        BLK_VAR,
        FRAME_UPD,
        DONE
    } bne_state_t;

    localparam logic MODE_MEAN = 1'b0;
    localparam logic MODE_MIN  = 1'b1;

    function automatic int ln_of(input int block_size);
        return 2 * $clog2(block_size);
    endfunction

    function automatic int sum_w(input int data_width, input int block_size);
        return data_width + ln_of(block_size);
    endfunction

    function automatic int sumsq_w(input int data_width, input int block_size);
        return 2 * data_width + ln_of(block_size);
    endfunction

    function automatic int acc_w(input int data_width, input int log2_max_blocks);
        return 2 * data_width + log2_max_blocks;
    endfunction

endpackage

// File: rtl/block_noise_estimator_var_acc.sv
// ---------------------------------------------------------------------------
// block_var_acc
// Per-pixel channel mean, per-block sum / sum-of-squares accumulation and
// the registered block variance.
//   clk, rst    : clock, synchronous active-high reset
//   pix_in      : packed multi-channel pixel
//   acc_en      : add the pixel mean into the running block sums
//   restart     : load the block sums with this pixel only (new frame)
//   var_load    : register the block variance and clear the block sums
//   var_q       : variance of the most recently completed block
// ---------------------------------------------------------------------------
module block_var_acc
    import block_noise_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int BLOCK_SIZE   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] pix_in,
    input  logic                               acc_en,
    input  logic                               restart,
    input  logic                               var_load,
    output logic [2*DATA_WIDTH-1:0]            var_q
);

    localparam int LN  = ln_of(BLOCK_SIZE);
    localparam int SW  = sum_w(DATA_WIDTH, BLOCK_SIZE);
    localparam int SQW = sumsq_w(DATA_WIDTH, BLOCK_SIZE);
    // Up to four channels summed needs two bits of headroom.
    localparam int CSW = DATA_WIDTH + 2;
    localparam int VW  = 2 * DATA_WIDTH;

    logic [CSW-1:0]        ch_sum;
    logic [DATA_WIDTH-1:0] pix_mean;
    logic [VW-1:0]         pix_sq;
    logic [SW-1:0]         sum_q, sum_d;
    logic [SQW-1:0]        sumsq_q, sumsq_d;
    logic [VW-1:0]         var_d;
    logic [VW-1:0]         mean_sq;
    logic [DATA_WIDTH-1:0] mean_blk;
    logic [VW-1:0]         mean_blk_sq;
    logic [VW-1:0]         var_c;

    always_comb begin
        ch_sum = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_sum = ch_sum + CSW'(pix_in[c*DATA_WIDTH +: DATA_WIDTH]);
        end
        pix_mean = DATA_WIDTH'(ch_sum / CSW'(NUM_CHANNELS));
        pix_sq   = VW'(pix_mean) * VW'(pix_mean);
    end

    // E[x^2] - E[x]^2 with both terms truncated; truncation can make the
    // difference negative on near-flat blocks, hence the clamp.
    always_comb begin
        mean_sq     = VW'(sumsq_q >> LN);
        mean_blk    = DATA_WIDTH'(sum_q >> LN);
        mean_blk_sq = VW'(mean_blk) * VW'(mean_blk);
        var_c       = (mean_sq > mean_blk_sq) ? (mean_sq - mean_blk_sq) : '0;
    end

    always_comb begin
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        var_d   = var_q;
        if (restart) begin
            sum_d   = SW'(pix_mean);
            sumsq_d = SQW'(pix_sq);
        end else if (var_load) begin
            sum_d   = '0;
            sumsq_d = '0;
            var_d   = var_c;
        end else if (acc_en) begin
            sum_d   = sum_q + SW'(pix_mean);
            sumsq_d = sumsq_q + SQW'(pix_sq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            sumsq_q <= '0;
            var_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            var_q   <= var_d;
        end
    end

endmodule

// File: rtl/block_noise_estimator.sv
// ---------------------------------------------------------------------------
// block_noise_estimator
// Per-frame noise estimate from a block-ordered multi-channel pixel stream.
// Each BLOCK_SIZE x BLOCK_SIZE block yields a variance; the frame result is
// the mean (mode 0) or minimum (mode 1) of the block variances.
//   clk, rst              : clock, synchronous active-high reset
//   s_data/s_valid/s_ready: pixel stream handshake, s_sof marks frame start
//   blocks_log2, mode     : frame configuration, sampled on accepted sof
//   estimated_noise       : last frame result, held
//   estimated_noise_valid : one-cycle pulse with each new result
//   busy                  : frame in progress
//   err_sof_midframe      : sticky, sof seen while a frame was accumulating
// Optional build macro BLOCK_NOISE_DEBUG_EN adds dbg_block_var,
// dbg_block_idx and dbg_block_valid (per-block variance trace).
// ---------------------------------------------------------------------------
module block_noise_estimator
    import block_noise_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_CHANNELS    = 3,
    parameter int BLOCK_SIZE      = 8,
    parameter int LOG2_MAX_BLOCKS = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
    input  logic                               s_valid,
    input  logic                               s_sof,
    output logic                               s_ready,
    input  logic [4:0]                         blocks_log2,
    input  logic                               mode,
    output logic [2*DATA_WIDTH-1:0]            estimated_noise,
    output logic                               estimated_noise_valid,
    output logic                               busy,
    output logic                               err_sof_midframe
`ifdef BLOCK_NOISE_DEBUG_EN
    ,
    output logic [2*DATA_WIDTH-1:0]            dbg_block_var,
    output logic [LOG2_MAX_BLOCKS-1:0]         dbg_block_idx,
    output logic                               dbg_block_valid
`endif
);

    localparam int LN  = ln_of(BLOCK_SIZE);
    localparam int N   = BLOCK_SIZE * BLOCK_SIZE;
    localparam int PCW = LN + 1;
    localparam int BCW = LOG2_MAX_BLOCKS + 1;
    localparam int AW  = acc_w(DATA_WIDTH, LOG2_MAX_BLOCKS);
    localparam int VW  = 2 * DATA_WIDTH;

    bne_state_t       state_q, state_d;
    logic             mode_q, mode_d;
    logic [4:0]       bl2_q, bl2_d;
    logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [BCW-1:0]   blk_cnt_q, blk_cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [VW-1:0]    min_q, min_d;
    logic [VW-1:0]    noise_q, noise_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             accept;
    logic             sof_acc;
    logic [4:0]       bl2_sat;
    logic [BCW-1:0]   blk_target;
    logic             acc_en;
    logic             restart;
    logic             var_load;
    logic [VW-1:0]    blk_var;

    assign s_ready               = (state_q == IDLE) || (state_q == ACCUM);
    assign busy                  = (state_q != IDLE);
    assign estimated_noise       = noise_q;
    assign estimated_noise_valid = valid_q;
    assign err_sof_midframe      = err_q;

    assign accept     = s_valid && s_ready;
    assign sof_acc    = accept && s_sof;
    assign bl2_sat    = (32'(blocks_log2) > LOG2_MAX_BLOCKS) ? 5'(LOG2_MAX_BLOCKS) : blocks_log2;
    assign blk_target = BCW'(1) << bl2_q;

    block_var_acc #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS),
        .BLOCK_SIZE   (BLOCK_SIZE)
    ) u_var_acc (
        .clk      (clk),
        .rst      (rst),
        .pix_in   (s_data),
        .acc_en   (acc_en),
        .restart  (restart),
        .var_load (var_load),
        .var_q    (blk_var)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        bl2_d     = bl2_q;
        pix_cnt_d = pix_cnt_q;
        blk_cnt_d = blk_cnt_q;
        acc_d     = acc_q;
        min_d     = min_q;
        noise_d   = noise_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        acc_en    = 1'b0;
        restart   = 1'b0;
        var_load  = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (sof_acc) begin
                    // A sof always (re)starts a frame; mid-frame it also
                    // flags the error and drops the partial frame.
                    if (state_q == ACCUM) begin
                        err_d = 1'b1;
                    end
                    mode_d    = mode;
                    bl2_d     = bl2_sat;
                    acc_d     = '0;
                    min_d     = '1;
                    blk_cnt_d = '0;
                    restart   = 1'b1;
                    pix_cnt_d = PCW'(1);
                    state_d   = (pix_cnt_d == PCW'(N)) ? BLK_VAR : ACCUM;
                end else if (accept && state_q == ACCUM) begin
                    acc_en    = 1'b1;
                    pix_cnt_d = pix_cnt_q + PCW'(1);
                    if (pix_cnt_d == PCW'(N)) begin
                        state_d = BLK_VAR;
                    end
                end
            end
            BLK_VAR: begin
                var_load  = 1'b1;
                pix_cnt_d = '0;
                state_d   = FRAME_UPD;
            end
            FRAME_UPD: begin
                acc_d     = acc_q + AW'(blk_var);
                min_d     = (blk_var < min_q) ? blk_var : min_q;
                blk_cnt_d = blk_cnt_q + BCW'(1);
                if (blk_cnt_d == blk_target) begin
                    // Result is registered here from the updated aggregate
                    // so the pulse lands in DONE, three cycles after the
                    // last pixel.
                    noise_d = (mode_q == MODE_MIN) ? min_d : VW'(acc_d >> bl2_q);
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_MEAN;
            bl2_q     <= '0;
            pix_cnt_q <= '0;
            blk_cnt_q <= '0;
            acc_q     <= '0;
            min_q     <= '0;
            noise_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            bl2_q     <= bl2_d;
            pix_cnt_q <= pix_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            acc_q     <= acc_d;
            min_q     <= min_d;
            noise_q   <= noise_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

`ifdef BLOCK_NOISE_DEBUG_EN
    logic                       dbg_valid_q, dbg_valid_d;
    logic [LOG2_MAX_BLOCKS-1:0] dbg_idx_q, dbg_idx_d;

    // Captured on the BLK_VAR edge so the trace is visible during FRAME_UPD,
    // alongside the freshly registered block variance.
    always_comb begin
        dbg_valid_d = (state_q == BLK_VAR);
        dbg_idx_d   = dbg_idx_q;
        if (state_q == BLK_VAR) begin
            dbg_idx_d = blk_cnt_q[LOG2_MAX_BLOCKS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_valid_q <= 1'b0;
            dbg_idx_q   <= '0;
        end else begin
            dbg_valid_q <= dbg_valid_d;
            dbg_idx_q   <= dbg_idx_d;
        end
    end

    assign dbg_block_var   = blk_var;
    assign dbg_block_idx   = dbg_idx_q;
    assign dbg_block_valid = dbg_valid_q;
`endif

endmodule

// File: tb/tb_block_noise_estimator.sv
module tb_block_noise_estimator;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_sof;
    logic        s_ready;
    logic [4:0]  blocks_log2;
    logic        mode;
    logic [15:0] estimated_noise;
    logic        estimated_noise_valid;
    logic        busy;
    logic        err_sof_midframe;

    block_noise_estimator #(
        .DATA_WIDTH      (8),
        .NUM_CHANNELS    (3),
        .BLOCK_SIZE      (8),
        .LOG2_MAX_BLOCKS (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_data                (s_data),
        .s_valid               (s_valid),
        .s_sof                 (s_sof),
        .s_ready               (s_ready),
        .blocks_log2           (blocks_log2),
        .mode                  (mode),
        .estimated_noise       (estimated_noise),
        .estimated_noise_valid (estimated_noise_valid),
        .busy                  (busy),
        .err_sof_midframe      (err_sof_midframe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int last_acc = 0;
    int gap [0:255];
    logic [23:0] fpx [0:255];

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int pix_mean(input logic [23:0] w);
        return (int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16])) / 3;
    endfunction

    function automatic int model_block_var(input int b);
        int s, sq, m, v;
        s = 0; sq = 0;
        for (int i = 0; i < 64; i++) begin
            m  = pix_mean(fpx[b*64 + i]);
            s  += m;
            sq += m * m;
        end
        v = sq / 64 - (s / 64) * (s / 64);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int model_frame(input int bl2, input bit m);
        int nb, tot, mn, v;
        nb = 1 << bl2; tot = 0; mn = 65535;
        for (int b = 0; b < nb; b++) begin
            v = model_block_var(b);
            tot += v;
            if (v < mn) mn = v;
        end
        return m ? mn : tot / nb;
    endfunction

    // ---------------- frame fill helpers ----------------
    function automatic logic [23:0] gray(input int g);
        logic [7:0] g8;
        g8 = 8'(g);
        return {g8, g8, g8};
    endfunction

    task automatic fill_flat(input int b, input int g);
        for (int i = 0; i < 64; i++) fpx[b*64+i] = gray(g);
    endtask

    task automatic fill_checker(input int b);
        for (int i = 0; i < 64; i++)
            fpx[b*64+i] = (((i / 8) + (i % 8)) % 2 == 1) ? gray(255) : gray(0);
    endtask

    task automatic fill_random(input int b);
        int lo, span, hi;
        lo   = $urandom_range(0, 255);
        span = $urandom_range(0, 255);
        hi   = (lo + span > 255) ? 255 : lo + span;
        for (int i = 0; i < 64; i++)
            fpx[b*64+i] = {8'($urandom_range(lo, hi)), 8'($urandom_range(lo, hi)),
                           8'($urandom_range(lo, hi))};
    endtask

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit sof_first, input bit stall);
        int lowrun;
        logic rdy;
        lowrun = 0;
        for (int i = 0; i < n; i++) begin
            int guard;
            bit done;
            guard = 0; done = 0;
            while (!done) begin
                s_data  = fpx[i];
                s_sof   = sof_first && (i == 0);
                s_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                rdy     = s_ready;
                if (!rdy) lowrun++;
                @(posedge clk); #1;
                if (s_valid && rdy) begin
                    done = 1;
                    last_acc = cyc;
                    if (i > 0) gap[i-1] = lowrun;
                    lowrun = 0;
                end
                guard++;
                if (!done && guard > 200) begin
                    checks++; failures++;
                    $display("FAIL send_timeout pixel=%0d not accepted within 200 cycles", i);
                    done = 1;
                end
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic wait_result(output bit got, output logic [15:0] v, output int lat);
        got = 0; v = '0; lat = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (estimated_noise_valid) begin
                got = 1; v = estimated_noise; lat = cyc - last_acc + 1;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (estimated_noise !== 16'd0) begin failures++; $display("FAIL reset_noise got=%0d exp=0", estimated_noise); end
        checks++; if (estimated_noise_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", estimated_noise_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_sof_midframe !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_sof_midframe); end
    endtask

    task automatic test_flat();
        bit got; logic [15:0] v; int lat;
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 4; b++) fill_flat(b, 100);
            blocks_log2 = 5'd2; mode = m[0];
            send_pixels(256, 1'b1, 1'b0);
            wait_result(got, v, lat);
            checks++;
            if (!got || v !== 16'd0) begin failures++; $display("FAIL flat_noise mode=%0d got=%0d valid=%0b exp=0", m, v, got); end
            checks++;
            if (lat != 3) begin failures++; $display("FAIL flat_latency mode=%0d got=%0d exp=3", m, lat); end
            @(posedge clk); #1;
            checks++;
            if (estimated_noise_valid !== 1'b0) begin failures++; $display("FAIL flat_pulse_width got=%b exp=0", estimated_noise_valid); end
        end
    endtask

    task automatic test_channel_mean();
        bit got; logic [15:0] v; int lat; int exp;
        for (int i = 0; i < 64; i++) fpx[i] = {8'd90, 8'd60, 8'd30};
        blocks_log2 = 5'd0; mode = 1'b0;
        send_pixels(64, 1'b1, 1'b0);
        wait_result(got, v, lat);
        checks++;
        if (!got || v !== 16'd0) begin failures++; $display("FAIL chmean_flat got=%0d valid=%0b exp=0", v, got); end
        // Distinct channels per pixel exercise the truncating divide-by-3.
        for (int t = 0; t < 3; t++) begin
            fill_random(0);
            send_pixels(64, 1'b1, 1'b0);
            wait_result(got, v, lat);
            exp = model_frame(0, 1'b0);
            checks++;
            if (!got || v !== 16'(exp)) begin failures++; $display("FAIL chmean_random t=%0d got=%0d exp=%0d", t, v, exp); end
        end
    endtask

    task automatic test_checker();
        bit got; logic [15:0] v; int lat;
        fill_checker(0); fill_flat(1, 50); fill_flat(2, 50); fill_flat(3, 50);
        blocks_log2 = 5'd2; mode = 1'b0;
        send_pixels(256, 1'b1, 1'b0);
        mode = 1'b1;  // changed after sof: must not affect this frame
        wait_result(got, v, lat);
        checks++;
        if (!got || v !== 16'd4095 || model_frame(2, 1'b0) != 4095) begin
            failures++; $display("FAIL checker_mean got=%0d exp=4095", v);
        end
        mode = 1'b1;
        send_pixels(256, 1'b1, 1'b0);
        wait_result(got, v, lat);
        checks++;
        if (!got || v !== 16'd0) begin failures++; $display("FAIL checker_min_one got=%0d exp=0", v); end
        fill_checker(0); fill_checker(1); fill_flat(2, 50); fill_checker(3);
        send_pixels(256, 1'b1, 1'b0);
        wait_result(got, v, lat);
        checks++;
        if (!got || v !== 16'd0) begin failures++; $display("FAIL checker_min_blk2flat got=%0d exp=0", v); end
        fill_checker(2);
        send_pixels(256, 1'b1, 1'b0);
        wait_result(got, v, lat);
        checks++;
        if (!got || v !== 16'd16383) begin failures++; $display("FAIL checker_min_all got=%0d exp=16383", v); end
    endtask

    task automatic test_random();
        bit got; logic [15:0] v; int lat; int bl2; bit m; int exp;
        for (int t = 0; t < 6; t++) begin
            bl2 = $urandom_range(0, 2);
            m   = 1'($urandom_range(0, 1));
            for (int b = 0; b < (1 << bl2); b++) fill_random(b);
            blocks_log2 = 5'(bl2); mode = m;
            send_pixels(64 << bl2, 1'b1, 1'b0);
            wait_result(got, v, lat);
            exp = model_frame(bl2, m);
            checks++;
            if (!got || v !== 16'(exp) || lat != 3) begin
                failures++;
                $display("FAIL random t=%0d bl2=%0d mode=%0d got=%0d lat=%0d exp=%0d lat_exp=3", t, bl2, m, v, lat, exp);
            end
        end
    endtask

    task automatic test_stall();
        bit got; logic [15:0] v_cont, v_stall; int lat; int exp; int bad;
        for (int b = 0; b < 4; b++) fill_random(b);
        blocks_log2 = 5'd2; mode = 1'b0;
        exp = model_frame(2, 1'b0);
        send_pixels(256, 1'b1, 1'b0);
        wait_result(got, v_cont, lat);
        send_pixels(256, 1'b1, 1'b1);
        wait_result(got, v_stall, lat);
        checks++;
        if (!got || v_stall !== 16'(exp) || v_stall !== v_cont) begin
            failures++; $display("FAIL stall_result got=%0d cont=%0d exp=%0d", v_stall, v_cont, exp);
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL stall_latency got=%0d exp=3", lat); end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (gap[k*64-1] != 2) begin failures++; $display("FAIL stall_block_gap blk=%0d got=%0d exp=2", k, gap[k*64-1]); end
        end
        bad = 0;
        for (int i = 0; i < 255; i++) if ((i % 64) != 63 && gap[i] != 0) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_inner_gap count=%0d exp=0", bad); end
    endtask

    task automatic test_midframe_sof();
        bit got; logic [15:0] v; int lat; int exp;
        for (int b = 0; b < 4; b++) fill_checker(b);
        blocks_log2 = 5'd2; mode = 1'b1;
        send_pixels(100, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1 || err_sof_midframe !== 1'b0) begin
            failures++; $display("FAIL midsof_pre busy=%b err=%b exp busy=1 err=0", busy, err_sof_midframe);
        end
        for (int b = 0; b < 4; b++) fill_random(b);
        mode = 1'b0;
        send_pixels(256, 1'b1, 1'b0);
        checks++;
        if (err_sof_midframe !== 1'b1) begin failures++; $display("FAIL midsof_err got=%b exp=1", err_sof_midframe); end
        wait_result(got, v, lat);
        exp = model_frame(2, 1'b0);
        checks++;
        if (!got || v !== 16'(exp) || lat != 3) begin
            failures++; $display("FAIL midsof_result got=%0d lat=%0d exp=%0d lat_exp=3", v, lat, exp);
        end
    endtask

    task automatic test_rst_midframe();
        bit got; logic [15:0] v; int lat;
        for (int b = 0; b < 4; b++) fill_random(b);
        blocks_log2 = 5'd2; mode = 1'b0;
        send_pixels(30, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || estimated_noise !== 16'd0 || estimated_noise_valid !== 1'b0 ||
            busy !== 1'b0 || err_sof_midframe !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid rdy=%b noise=%0d valid=%b busy=%b err=%b exp 1/0/0/0/0",
                     s_ready, estimated_noise, estimated_noise_valid, busy, err_sof_midframe);
        end
        fill_checker(0);
        blocks_log2 = 5'd0; mode = 1'b1;
        send_pixels(64, 1'b1, 1'b0);
        wait_result(got, v, lat);
        checks++;
        if (!got || v !== 16'd16383) begin failures++; $display("FAIL rst_recover got=%0d exp=16383", v); end
    endtask

    initial begin
        blocks_log2 = 5'd0; mode = 1'b0;
        s_data = '0; s_valid = 1'b0; s_sof = 1'b0; rst = 1'b1;
        test_reset();
        test_flat();
        test_channel_mean();
        test_checker();
        test_random();
        test_stall();
        test_midframe_sof();
        test_rst_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
